// File: rtl/ompss_manager_pkg.sv
// Shared command/ack encodings for the OmpSs manager blocks.
// Field bounds address bits of the 64-bit command word.
package OmpSsManager;

  localparam int CMD_TYPE_L   = 0;
  localparam int CMD_TYPE_H   = 7;
  localparam int LOCK_ID_L    = 8;
  localparam int LOCK_ID_H    = 15;
  localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;

  localparam logic [CMD_TYPE_H-CMD_TYPE_L:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [CMD_TYPE_H-CMD_TYPE_L:0] CMD_UNLOCK_CODE = 8'h05;

  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;

endpackage

// File: rtl/multi_lock.sv
// Lock table arbitrating mutual exclusion between accelerators.
// One command per pass; only lock commands produce an ack.
module multi_lock
  import OmpSsManager::*;
#(
  parameter int MAX_ACCS  = 16,
  parameter int NUM_LOCKS = 8,
  localparam int ACC_BITS = $clog2(MAX_ACCS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [63:0]         inStream_TDATA,
  input  logic                inStream_TVALID,
  input  logic [ACC_BITS-1:0] inStream_TID,
  output logic                inStream_TREADY,
  output logic [7:0]          outStream_TDATA,
  output logic                outStream_TVALID,
  input  logic                outStream_TREADY,
  output logic [ACC_BITS-1:0] outStream_TDEST,
  output logic [NUM_LOCKS-1:0] lock_status
);

  localparam int CMD_BITS = CMD_TYPE_H - CMD_TYPE_L + 1;
  localparam int IDX_BITS = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
  localparam logic [LOCK_ID_BITS:0] NUM_LOCKS_W =
    NUM_LOCKS[LOCK_ID_BITS:0];

  typedef enum logic [1:0] {
    READ_HEADER,
    CHECK_LOCK,
    SEND_ACK
  } state_t;

  state_t state;
  state_t next_state;

  logic [NUM_LOCKS-1:0] held;
  logic [ACC_BITS-1:0]  owner [NUM_LOCKS];
  logic [ACC_BITS-1:0]  acc_id;
  logic [CMD_BITS-1:0]  cmd_type;
  logic [LOCK_ID_BITS-1:0] lock_id;
  logic [7:0]           ack_data;

  logic                 id_ok;
  logic [IDX_BITS-1:0]  idx;
  logic                 is_lock;
  logic                 is_unlock;
  logic                 grant;
  logic                 release_lk;
  logic                 accept;
  logic                 unused_tdata;

  assign unused_tdata = ^inStream_TDATA;

  assign accept    = (state == READ_HEADER) && inStream_TVALID;
  assign id_ok     = {1'b0, lock_id} < NUM_LOCKS_W;
  // Range check uses the full field; only then do the low bits index.
  assign idx       = lock_id[IDX_BITS-1:0];
  assign is_lock   = cmd_type == CMD_LOCK_CODE;
  assign is_unlock = cmd_type == CMD_UNLOCK_CODE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= READ_HEADER;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    release_lk = 1'b0;
    unique case (state)
      READ_HEADER: begin
        if (inStream_TVALID) next_state = CHECK_LOCK;
      end
      CHECK_LOCK: begin
        next_state = READ_HEADER;
        unique case (1'b1)
          is_lock: begin
            next_state = SEND_ACK;
            grant      = id_ok && !held[idx];
          end
          is_unlock: begin
            release_lk = id_ok && held[idx] &&
                         (owner[idx] == acc_id);
          end
          default: ;
        endcase
      end
      SEND_ACK: begin
        if (outStream_TREADY) next_state = READ_HEADER;
      end
      default: next_state = READ_HEADER;
    endcase
  end

  always_comb begin
    inStream_TREADY  = (state == READ_HEADER);
    outStream_TVALID = (state == SEND_ACK);
    outStream_TDATA  = ack_data;
    outStream_TDEST  = acc_id;
    lock_status      = held;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held <= '0;
    end else if (grant) begin
      held[idx] <= 1'b1;
    end else if (release_lk) begin
      held[idx] <= 1'b0;
    end
  end

  // Datapath registers carry no reset: they are rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_id   <= inStream_TID;
      cmd_type <= inStream_TDATA[CMD_TYPE_H:CMD_TYPE_L];
      lock_id  <= inStream_TDATA[LOCK_ID_H:LOCK_ID_L];
    end
    if (state == CHECK_LOCK) begin
      ack_data <= grant ? ACK_OK_CODE : ACK_REJECT_CODE;
    end
    if (grant) begin
      owner[idx] <= acc_id;
    end
  end

endmodule

// File: tb/tb_multi_lock.sv
// Directed bench for multi_lock: grant, contention, unlock,
// range, backpressure and reset during a pending ack.
module tb_multi_lock;
  import OmpSsManager::*;

  localparam int MAX_ACCS  = 16;
  localparam int NUM_LOCKS = 8;
  localparam int ACC_BITS  = $clog2(MAX_ACCS);

  logic                 clk;
  logic                 rstn;
  logic [63:0]          in_tdata;
  logic                 in_tvalid;
  logic [ACC_BITS-1:0]  in_tid;
  logic                 in_tready;
  logic [7:0]           out_tdata;
  logic                 out_tvalid;
  logic                 out_tready;
  logic [ACC_BITS-1:0]  out_tdest;
  logic [NUM_LOCKS-1:0] lock_status;

  int checks;
  int failures;

  multi_lock #(
    .MAX_ACCS (MAX_ACCS),
    .NUM_LOCKS(NUM_LOCKS)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .inStream_TDATA  (in_tdata),
    .inStream_TVALID (in_tvalid),
    .inStream_TID    (in_tid),
    .inStream_TREADY (in_tready),
    .outStream_TDATA (out_tdata),
    .outStream_TVALID(out_tvalid),
    .outStream_TREADY(out_tready),
    .outStream_TDEST (out_tdest),
    .lock_status     (lock_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] CMD_OTHER = 8'h7F;

  task automatic send_cmd(input logic [7:0] cmd,
                          input logic [7:0] id,
                          input logic [ACC_BITS-1:0] tid);
    bit done;
    done      = 1'b0;
    in_tdata  = {48'h0, id, cmd};
    in_tid    = tid;
    in_tvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_tready) done = 1'b1;
      @(posedge clk);
    end
    #1;
    in_tvalid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout cmd=%h id=%0d", cmd, id);
    end
  endtask

  task automatic expect_ack(input string name,
                            input logic [7:0] exp_data,
                            input logic [ACC_BITS-1:0] exp_dest,
                            output int lat);
    bit seen;
    seen       = 1'b0;
    lat        = 0;
    out_tready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_tvalid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_valid got=0 want=1", name);
    end else begin
      checks++;
      if (out_tdata !== exp_data || out_tdest !== exp_dest) begin
        failures++;
        $display("FAIL %s_ack got=%h/%0d want=%h/%0d",
                 name, out_tdata, out_tdest, exp_data, exp_dest);
      end
    end
    @(posedge clk);
    #1;
    out_tready = 1'b0;
  endtask

  task automatic expect_no_ack(input string name);
    bit bad;
    bad = 1'b0;
    out_tready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_tvalid !== 1'b0) bad = 1'b1;
    end
    @(posedge clk);
    #1;
    out_tready = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s_no_ack got=valid want=idle", name);
    end
  endtask

  task automatic check_status(input string name,
                              input logic [NUM_LOCKS-1:0] exp);
    checks++;
    if (lock_status !== exp) begin
      failures++;
      $display("FAIL %s_status got=%b want=%b",
               name, lock_status, exp);
    end
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tid     = '0;
    out_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_status("reset", '0);
    checks++;
    if (out_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_tvalid got=%b want=0", out_tvalid);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready got=%b want=1", in_tready);
    end
  endtask

  task automatic test_grant();
    int lat;
    send_cmd(CMD_LOCK_CODE, 8'd3, 4'd5);
    expect_ack("grant", ACK_OK_CODE, 4'd5, lat);
    check_status("grant", 8'b0000_1000);
  endtask

  task automatic test_contention();
    int lat;
    send_cmd(CMD_LOCK_CODE, 8'd3, 4'd2);
    expect_ack("contend_other", ACK_REJECT_CODE, 4'd2, lat);
    send_cmd(CMD_LOCK_CODE, 8'd3, 4'd5);
    expect_ack("contend_self", ACK_REJECT_CODE, 4'd5, lat);
    check_status("contend", 8'b0000_1000);
  endtask

  task automatic test_unlock();
    int lat;
    send_cmd(CMD_UNLOCK_CODE, 8'd3, 4'd2);
    expect_no_ack("unlock_nonowner");
    check_status("unlock_nonowner", 8'b0000_1000);
    send_cmd(CMD_UNLOCK_CODE, 8'd3, 4'd5);
    expect_no_ack("unlock_owner");
    check_status("unlock_owner", 8'b0000_0000);
    send_cmd(CMD_LOCK_CODE, 8'd3, 4'd2);
    expect_ack("relock", ACK_OK_CODE, 4'd2, lat);
    check_status("relock", 8'b0000_1000);
  endtask

  task automatic test_range();
    int lat;
    send_cmd(CMD_LOCK_CODE, 8'd8, 4'd1);
    expect_ack("lock_oob", ACK_REJECT_CODE, 4'd1, lat);
    check_status("lock_oob", 8'b0000_1000);
    send_cmd(CMD_UNLOCK_CODE, 8'd8, 4'd1);
    expect_no_ack("unlock_oob");
    check_status("unlock_oob", 8'b0000_1000);
    send_cmd(CMD_LOCK_CODE, 8'd11, 4'd1);
    expect_ack("lock_alias", ACK_REJECT_CODE, 4'd1, lat);
    check_status("lock_alias", 8'b0000_1000);
    send_cmd(CMD_OTHER, 8'd1, 4'd1);
    expect_no_ack("other_cmd");
    check_status("other_cmd", 8'b0000_1000);
  endtask

  task automatic test_back_to_back();
    int lat;
    send_cmd(CMD_LOCK_CODE, 8'd7, 4'd9);
    expect_ack("b2b_lock", ACK_OK_CODE, 4'd9, lat);
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL b2b_latency got=%0d want=2", lat);
    end
    send_cmd(CMD_UNLOCK_CODE, 8'd7, 4'd9);
    send_cmd(CMD_LOCK_CODE, 8'd7, 4'd15);
    expect_ack("b2b_relock", ACK_OK_CODE, 4'd15, lat);
    check_status("b2b", 8'b1000_1000);
  endtask

  task automatic test_backpressure();
    bit seen;
    bit bad;
    seen = 1'b0;
    bad  = 1'b0;
    out_tready = 1'b0;
    send_cmd(CMD_LOCK_CODE, 8'd0, 4'd6);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_tvalid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_valid got=0 want=1");
    end
    repeat (5) begin
      @(negedge clk);
      if (out_tvalid !== 1'b1 || out_tdata !== ACK_OK_CODE ||
          out_tdest !== 4'd6 || in_tready !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold got=v%b d%h t%0d r%b want=v1 d%h t6 r0",
               out_tvalid, out_tdata, out_tdest, in_tready,
               ACK_OK_CODE);
    end
    check_status("bp", 8'b1000_1001);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_rst_tvalid got=%b want=0", out_tvalid);
    end
    check_status("bp_rst", '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_tready !== 1'b1 || out_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_after_rst got=r%b v%b want=r1 v0",
               in_tready, out_tvalid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_grant();
    test_contention();
    test_unlock();
    test_range();
    test_back_to_back();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_lock.md
MULTI_LOCK -- requirements
Module: multi_lock

Interface
REQ-001 SHALL have parameter MAX_ACCS, default 16: number of accelerators; ACC_BITS = $clog2(MAX_ACCS).
REQ-002 SHALL have parameter NUM_LOCKS, default 8: number of independent locks; legal range 1 .. 2^LOCK_ID_BITS.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: rstn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: inStream_TDATA  in  64  command word (type at CMD_TYPE_H:CMD_TYPE_L, lock id at LOCK_ID_H:LOCK_ID_L).
REQ-006 SHALL have ports: inStream_TVALID  in  1, inStream_TID  in  ACC_BITS  requesting accelerator, inStream_TREADY  out  1.
REQ-007 SHALL have ports: outStream_TDATA  out  8  ack code, outStream_TVALID  out  1, outStream_TREADY  in  1, outStream_TDEST  out  ACC_BITS  ack destination.
REQ-008 SHALL have port: lock_status  out  NUM_LOCKS  bit i = lock i held.

Function
REQ-009 SHALL keep per lock: held bit and owner (ACC_BITS).
REQ-010 SHALL run FSM READ_HEADER -> CHECK_LOCK -> (SEND_ACK | READ_HEADER); inStream_TREADY = 1 only in READ_HEADER.
REQ-011 In READ_HEADER, on TVALID: latch TID, cmd type, lock id; go to CHECK_LOCK next cycle.
REQ-012 CHECK_LOCK, lock cmd, id < NUM_LOCKS, lock free: set held, owner = TID, ack = ACK_OK_CODE, go SEND_ACK.
REQ-013 CHECK_LOCK, lock cmd, lock held (any owner, including requester): no state change, ack = ACK_REJECT_CODE, go SEND_ACK.
REQ-014 CHECK_LOCK, lock cmd, id >= NUM_LOCKS: ack = ACK_REJECT_CODE, go SEND_ACK.
REQ-015 CHECK_LOCK, unlock cmd, id valid, held and owner == TID: clear held; no ack; go READ_HEADER.
REQ-016 Unlock by non-owner, of a free lock, or with id >= NUM_LOCKS: ignored, no ack, go READ_HEADER.
REQ-017 Any other cmd type: consumed, ignored, no ack, go READ_HEADER.
REQ-018 SEND_ACK: outStream_TVALID = 1; TDATA/TDEST stable until TREADY; on TREADY go READ_HEADER.
REQ-019 Lock-table update SHALL be visible on lock_status the cycle after CHECK_LOCK (registered); a command in the next READ_HEADER sees the updated table.
REQ-020 Latency: lock ack TVALID asserts 2 cycles after the accepting handshake; throughput: 1 command per 2 cycles (unlock/other), 3+ cycles (lock).
REQ-021 Only the low $clog2(NUM_LOCKS) lock-id bits index the table, after the range check on the full LOCK_ID_BITS field.

Reset
REQ-022 rstn low SHALL asynchronously force: state = READ_HEADER, all held = 0, lock_status = 0, outStream_TVALID = 0, inStream_TREADY = 1 after release.
REQ-023 Reset mid-SEND_ACK SHALL drop the pending ack; owners, acc id and ack data registers need no reset.

Structure
REQ-024 Command-field bounds, LOCK_ID_BITS, CMD_LOCK_CODE, CMD_UNLOCK_CODE, ACK_OK_CODE, ACK_REJECT_CODE SHALL come from package OmpSsManager; no new package entries.
REQ-025 FSM state enum local to the module; single flat module, no sub-module.

Verification
REQ-026 Lock id 3 from acc 5 after reset -> ack ACK_OK_CODE, TDEST 5, lock_status = 8'b0000_1000.
REQ-027 Then lock id 3 from acc 2 -> ACK_REJECT_CODE to TDEST 2; lock id 3 from acc 5 -> ACK_REJECT_CODE; status unchanged.
REQ-028 Unlock id 3 from acc 2 -> no ack, bit 3 stays 1; unlock id 3 from acc 5 -> no ack, bit 3 clears; lock id 3 from acc 2 -> ACK_OK_CODE.
REQ-029 Lock id NUM_LOCKS (8) -> ACK_REJECT_CODE, lock_status unchanged; unlock id 8 -> no ack, no change.
REQ-030 Lock id 0 with outStream_TREADY low 5 cycles -> TVALID held, TDATA/TDEST stable, inStream_TREADY 0 throughout; rstn pulse during this -> TVALID 0 immediately, lock_status 0.
